// File: rtl/seven_segment_scan_driver.sv
// Multiplexed seven-segment scan driver: one digit is lit at a time, with a dead cycle between digits.
// Optional macro SEG_LEADING_ZERO_BLANK_EN darkens leading zero digits above position 0.
module seven_segment_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int PCNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
   logic                    first_q;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    frame_tick_q, frame_tick_d;

   logic                    pcnt_wrap;
   logic                    frame_wrap;
   logic                    capture;
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [3:0]              nib;
   logic                    dark;
   logic                    dp_bit;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Scan counters and shadow capture; first_q forces a capture on the first edge out of reset.
   always_comb begin
      pcnt_wrap  = (pcnt_q == PCNT_LAST);
      frame_wrap = pcnt_wrap && (idx_q == IDX_LAST);
      capture    = frame_wrap || first_q;
      pcnt_d     = pcnt_wrap ? '0 : pcnt_q + 1'b1;
      idx_d      = idx_q;
      if (pcnt_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      sh_value_d   = capture ? value    : sh_value_q;
      sh_dp_d      = capture ? dp_in    : sh_dp_q;
      sh_en_d      = capture ? digit_en : sh_en_q;
      frame_tick_d = frame_wrap;
   end

   always_comb begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
      lz_blank = '0;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         lz_blank[k] = ((sh_value_q >> (4 * k)) == '0) && ((sh_dp_q >> k) == '0);
      end
`else
      lz_blank = '0;
`endif
   end

   // Output decode from the current (pre-edge) scan state, registered for one cycle of latency.
   always_comb begin
      nib    = 4'h0;
      dark   = 1'b1;
      dp_bit = 1'b0;
      an_d   = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib    = sh_value_q[4*k +: 4];
            dark   = (pcnt_q == '0) || !sh_en_q[k] || lz_blank[k];
            dp_bit = sh_dp_q[k];
            an_d[k] = dark;
         end
      end
      seg_d = dark ? 7'b1111111 : hex_to_seg(nib);
      dp_d  = dark ? 1'b1 : ~dp_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q       <= '0;
         idx_q        <= '0;
         sh_value_q   <= '0;
         sh_dp_q      <= '0;
         sh_en_q      <= '0;
         first_q      <= 1'b1;
         seg_q        <= 7'b1111111;
         dp_q         <= 1'b1;
         an_q         <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         pcnt_q       <= pcnt_d;
         idx_q        <= idx_d;
         sh_value_q   <= sh_value_d;
         sh_dp_q      <= sh_dp_d;
         sh_en_q      <= sh_en_d;
         first_q      <= 1'b0;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Self-checking bench for seven_segment_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4) against a cycle-count model.
module tb_seven_segment_scan_driver;
   localparam int ND = 4;
   localparam int RD = 4;
   localparam int FRAME = ND * RD;
`ifdef SEG_LEADING_ZERO_BLANK_EN
   localparam bit LZ_EN = 1'b1;
`else
   localparam bit LZ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   seven_segment_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
      .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int e = 0;               // rising edges since reset release
   logic [15:0] sh_val;
   logic [3:0]  sh_dp, sh_en;
   logic [6:0]  exp_seg;
   logic        exp_dp, exp_ft;
   logic [3:0]  exp_an;
   logic [6:0]  hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   function automatic bit lz_blank(int ix);
      return LZ_EN && ix > 0 && (sh_val >> (4 * ix)) == 16'h0 && (sh_dp >> ix) == 4'h0;
   endfunction

   // Outputs after edge e show the scan position reached after e-1 edges and the shadow held then.
   task automatic step();
      int pc, ix;
      bit blank;
      logic [3:0] nibv;
      @(posedge clk);
      e++;
      pc = (e - 1) % RD;
      ix = ((e - 1) / RD) % ND;
      blank = (pc == 0) || !sh_en[ix] || lz_blank(ix);
      nibv = 4'(sh_val >> (4 * ix));
      exp_an  = blank ? 4'hF : ~(4'b0001 << ix);
      exp_seg = blank ? 7'h7F : hex_tab[nibv];
      exp_dp  = blank ? 1'b1 : ~sh_dp[ix];
      exp_ft  = (e >= FRAME) && (e % FRAME == 0);
      if (e == 1 || exp_ft) begin
         sh_val = value; sh_dp = dp_in; sh_en = digit_en;
      end
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      e = 0; sh_val = '0; sh_dp = '0; sh_en = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      value = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold got an=%b seg=%b dp=%b ft=%b exp 1111/1111111/1/0", an, seg, dp, frame_tick);
         end
      end
   endtask

   task automatic test_scan_12af();
      int ft_cnt = 0;
      value = 16'h12AF; digit_en = 4'hF; dp_in = 4'h0;
      release_reset();
      for (int i = 0; i < 40; i++) begin
         step();
         ft_cnt += int'(frame_tick);
         checks++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
            errors++;
            $display("FAIL scan_12af e=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", e, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
         end
         if (e == 3 || e == 7 || e == 11 || e == 15) begin
            checks++;
            if ({an, seg} !== (e == 3 ? {4'b1110, 7'b0001110} : e == 7 ? {4'b1101, 7'b0001000} :
                               e == 11 ? {4'b1011, 7'b0100100} : {4'b0111, 7'b1111001})) begin
               errors++;
               $display("FAIL scan_12af_digit e=%0d got an=%b seg=%b", e, an, seg);
            end
         end
      end
      checks++;
      if (ft_cnt !== 2) begin
         errors++;
         $display("FAIL frame_tick_count got %0d exp 2", ft_cnt);
      end
   endtask

   task automatic test_shadow_hold();
      bit seen_ft = 0;
      bit seen5 = 0;
      for (int i = 0; i < FRAME && ((e / RD) % ND) != 1; i++) step();
      value = 16'h5555;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         checks++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
            errors++;
            $display("FAIL shadow_hold e=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", e, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
         end
         if (!seen_ft && an != 4'hF) begin
            checks++;
            if (seg === 7'b0010010) begin
               errors++;
               $display("FAIL shadow_hold_early e=%0d got seg=%b before next frame", e, seg);
            end
         end
         if (seen_ft && an == 4'b1110) seen5 = seen5 || (seg == 7'b0010010);
         if (frame_tick) seen_ft = 1;
      end
      checks++;
      if (seen5 !== 1'b1) begin
         errors++;
         $display("FAIL shadow_hold_update got seen5=%b exp 1", seen5);
      end
   endtask

   task automatic test_enable_dp();
      bit seen_ft = 0;
      value = 16'($urandom); digit_en = 4'b0101; dp_in = 4'b0001;
      for (int i = 0; i < 3 * FRAME; i++) begin
         step();
         checks++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
            errors++;
            $display("FAIL enable_dp e=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", e, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
         end
         if (seen_ft) begin
            checks++;
            if (an[1] !== 1'b1 || an[3] !== 1'b1 || (dp == 1'b0) !== (an == 4'b1110)) begin
               errors++;
               $display("FAIL enable_dp_rule e=%0d got an=%b dp=%b", e, an, dp);
            end
         end
         if (frame_tick) seen_ft = 1;
      end
   endtask

   task automatic test_leading_zero();
      bit seen_ft = 0;
      int upper_lit = 0;
      value = 16'h0034; digit_en = 4'hF; dp_in = 4'h0;
      for (int i = 0; i < 2 * FRAME + 1; i++) begin
         step();
         checks++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
            errors++;
            $display("FAIL leading_zero e=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", e, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
         end
         if (seen_ft && (an == 4'b1011 || an == 4'b0111)) begin
            upper_lit++;
            checks++;
            if (seg !== 7'b1000000) begin
               errors++;
               $display("FAIL leading_zero_seg e=%0d got seg=%b exp 1000000", e, seg);
            end
         end
         if (frame_tick) seen_ft = 1;
      end
      checks++;
      if (upper_lit !== (LZ_EN ? 0 : 2 * (RD - 1))) begin
         errors++;
         $display("FAIL leading_zero_count got %0d lit cycles of digits 2/3", upper_lit);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8 * FRAME; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            value = 16'($urandom);
            if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
            dp_in = 4'($urandom_range(0, 15)) & 4'($urandom);
            digit_en = 4'($urandom);
         end
         step();
         checks++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
            errors++;
            $display("FAIL random e=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", e, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
         end
      end
   endtask

   task automatic test_async_reset();
      digit_en = 4'hF;
      for (int i = 0; i < FRAME + 2 && !(e % RD == 2 && (e / RD) % ND == 2); i++) step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL async_reset got an=%b seg=%b dp=%b ft=%b exp 1111/1111111/1/0", an, seg, dp, frame_tick);
      end
      value = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'hF;
      release_reset();
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         checks++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
            errors++;
            $display("FAIL after_reset e=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", e, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
         end
         if (e == 2) begin
            checks++;
            if ({an, seg} !== {4'b1110, hex_tab[value[3:0]]}) begin
               errors++;
               $display("FAIL restart_digit0 got an=%b seg=%b", an, seg);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_12af();
      test_shadow_hold();
      test_enable_dp();
      test_leading_zero();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
